// File: rtl/robot_cmd_arbiter.sv
// robot_cmd_arbiter: round-robin owner of a shared actuator command bus with a grant-to-done watchdog.
module robot_cmd_arbiter #(
  parameter int CMD_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [3:0]         i_req,
  input  logic [4*CMD_W-1:0] i_cmd,
  output logic [3:0]         o_gnt,
  output logic               o_act_valid,
  output logic [CMD_W-1:0]   o_act_cmd,
  input  logic               i_act_ready,
  input  logic               i_act_done,
  output logic               o_busy,
  output logic               o_fault,
  output logic [1:0]         o_fault_id,
  input  logic               i_clr_fault,
  output logic [15:0]        o_cmd_count
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, RELEASE, FAULT} state_t;
  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_timer;
  logic [1:0]    r_rr_ptr, r_win, w_win, w_off;
  logic [3:0]    w_req_rot;
  logic          w_timeout;
  // rotate requests so bit 0 is the current round-robin head
  assign w_req_rot = 4'({i_req, i_req} >> r_rr_ptr);
  assign w_off     = w_req_rot[0] ? 2'd0 : w_req_rot[1] ? 2'd1 : w_req_rot[2] ? 2'd2 : 2'd3;
  assign w_win     = r_rr_ptr + w_off;
  // the watchdog trips on the edge where the timer would reach TIMEOUT
  assign w_timeout = (32'(r_timer) + 32'd1) == 32'(TIMEOUT);
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      w_state_nxt = |i_req ? ISSUE : IDLE;
      ISSUE:     w_state_nxt = w_timeout ? FAULT : i_act_ready ? WAIT_DONE : ISSUE;
      WAIT_DONE: w_state_nxt = i_act_done ? RELEASE : w_timeout ? FAULT : WAIT_DONE;
      RELEASE:   w_state_nxt = IDLE;
      FAULT:     w_state_nxt = i_clr_fault ? IDLE : FAULT;
      default:   w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_gnt       <= '0;
      o_act_valid <= 1'b0;
      o_act_cmd   <= '0;
      o_busy      <= 1'b0;
      o_fault     <= 1'b0;
      o_fault_id  <= '0;
      o_cmd_count <= '0;
      r_rr_ptr    <= '0;
      r_win       <= '0;
      r_timer     <= '0;
    end else begin
      if (r_state == IDLE && |i_req) begin
        r_win       <= w_win;
        o_gnt       <= 4'b0001 << w_win;
        o_act_cmd   <= i_cmd[w_win*CMD_W +: CMD_W];
        o_act_valid <= 1'b1;
        o_busy      <= 1'b1;
        r_timer     <= '0;
      end
      if (r_state == ISSUE || r_state == WAIT_DONE) r_timer <= r_timer + TW'(1);
      if (r_state == ISSUE && w_state_nxt == WAIT_DONE) o_act_valid <= 1'b0;
      if (r_state != FAULT && w_state_nxt == FAULT) begin
        o_gnt       <= '0;
        o_act_valid <= 1'b0;
        o_fault     <= 1'b1;
        o_fault_id  <= r_win;
      end
      if (r_state == RELEASE) begin
        o_gnt       <= '0;
        o_busy      <= 1'b0;
        o_cmd_count <= o_cmd_count + 16'd1;
        r_rr_ptr    <= r_win + 2'd1;
      end
      if (r_state == FAULT && i_clr_fault) begin
        o_fault  <= 1'b0;
        o_busy   <= 1'b0;
        r_rr_ptr <= o_fault_id + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_robot_cmd_arbiter.sv
// tb_robot_cmd_arbiter: vector table, directed corner sequences and a randomized run against a transaction-level model.
module tb_robot_cmd_arbiter;
  localparam int W = 8;
  logic         clk = 1'b0, rst_n = 1'b0;
  logic [3:0]   req = '0;
  logic [4*W-1:0] cmd = '0;
  logic         ready = 1'b0, done = 1'b0, clr = 1'b0;
  logic [3:0]   gnt[2];
  logic         valid[2], busy[2], fault[2];
  logic [W-1:0] acmd[2];
  logic [1:0]   fid[2];
  logic [15:0]  cnt[2];
  int total = 0, bad = 0;

  robot_cmd_arbiter #(.CMD_W(W), .TIMEOUT(255)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_cmd(cmd), .o_gnt(gnt[0]), .o_act_valid(valid[0]),
    .o_act_cmd(acmd[0]), .i_act_ready(ready), .i_act_done(done), .o_busy(busy[0]), .o_fault(fault[0]),
    .o_fault_id(fid[0]), .i_clr_fault(clr), .o_cmd_count(cnt[0]));
  robot_cmd_arbiter #(.CMD_W(W), .TIMEOUT(4)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_cmd(cmd), .o_gnt(gnt[1]), .o_act_valid(valid[1]),
    .o_act_cmd(acmd[1]), .i_act_ready(ready), .i_act_done(done), .o_busy(busy[1]), .o_fault(fault[1]),
    .o_fault_id(fid[1]), .i_clr_fault(clr), .o_cmd_count(cnt[1]));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req; logic [7:0] c0; logic rdy; logic dn;
    logic [3:0] g; logic v; logic [7:0] ac; logic b; logic [15:0] n;
  } vec_t;
  vec_t tv[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; req = '0; ready = 1'b0; done = 1'b0; clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic txn0;
    req = 4'b0001; ready = 1'b1; done = 1'b1;
    step; req = '0; step; step; step;
    ready = 1'b0; done = 1'b0;
  endtask

  initial begin
    logic [3:0] prev;
    logic [3:0] got_g[$];
    logic [7:0] got_c[$];
    int         got_e[$];
    logic [3:0] exp_g[5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    logic [7:0] exp_c[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    int n;
    int m_owner, m_age, m_fid, m_rr, m_cnt, w;
    bit m_acked, m_done, m_fault;
    logic [7:0] m_cmd;

    tv[0] = '{4'b0001, 8'hA5, 1'b0, 1'b0, 4'b0001, 1'b1, 8'hA5, 1'b1, 16'd0};
    tv[1] = '{4'b0000, 8'hA5, 1'b0, 1'b1, 4'b0001, 1'b1, 8'hA5, 1'b1, 16'd0};
    tv[2] = '{4'b0000, 8'h3C, 1'b0, 1'b0, 4'b0001, 1'b1, 8'hA5, 1'b1, 16'd0};
    tv[3] = '{4'b0000, 8'h3C, 1'b1, 1'b0, 4'b0001, 1'b0, 8'hA5, 1'b1, 16'd0};
    tv[4] = '{4'b0000, 8'h3C, 1'b0, 1'b0, 4'b0001, 1'b0, 8'hA5, 1'b1, 16'd0};
    tv[5] = '{4'b0000, 8'h3C, 1'b1, 1'b0, 4'b0001, 1'b0, 8'hA5, 1'b1, 16'd0};
    tv[6] = '{4'b0000, 8'h3C, 1'b0, 1'b1, 4'b0001, 1'b0, 8'hA5, 1'b1, 16'd0};
    tv[7] = '{4'b0000, 8'h3C, 1'b0, 1'b0, 4'b0000, 1'b0, 8'hA5, 1'b0, 16'd1};
    tv[8] = '{4'b0000, 8'h3C, 1'b0, 1'b0, 4'b0000, 1'b0, 8'hA5, 1'b0, 16'd1};

    #2;
    for (int s = 0; s < 2; s++) begin
      chk("rst_gnt", 32'(gnt[s]), 0);
      chk("rst_valid", 32'(valid[s]), 0);
      chk("rst_busy", 32'(busy[s]), 0);
      chk("rst_fault", 32'(fault[s]), 0);
      chk("rst_cnt", 32'(cnt[s]), 0);
    end
    do_reset;

    for (int i = 0; i < 9; i++) begin
      req = tv[i].req; cmd[7:0] = tv[i].c0; ready = tv[i].rdy; done = tv[i].dn;
      step;
      chk($sformatf("vec%0d_gnt", i), 32'(gnt[0]), 32'(tv[i].g));
      chk($sformatf("vec%0d_valid", i), 32'(valid[0]), 32'(tv[i].v));
      chk($sformatf("vec%0d_cmd", i), 32'(acmd[0]), 32'(tv[i].ac));
      chk($sformatf("vec%0d_busy", i), 32'(busy[0]), 32'(tv[i].b));
      chk($sformatf("vec%0d_cnt", i), 32'(cnt[0]), 32'(tv[i].n));
    end

    do_reset;
    cmd = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'hF; ready = 1'b1; done = 1'b1; prev = '0;
    for (int e = 0; e < 40 && got_g.size() < 5; e++) begin
      step;
      if (gnt[0] != 0 && prev == 0) begin
        got_g.push_back(gnt[0]); got_c.push_back(acmd[0]); got_e.push_back(e);
      end
      prev = gnt[0];
    end
    req = '0;
    chk("rr_grants", got_g.size(), 5);
    for (int k = 0; k < got_g.size(); k++) begin
      chk($sformatf("rr_gnt%0d", k), 32'(got_g[k]), 32'(exp_g[k]));
      chk($sformatf("rr_cmd%0d", k), 32'(got_c[k]), 32'(exp_c[k]));
      if (k > 0) chk($sformatf("rr_gap%0d", k), got_e[k] - got_e[k-1], 4);
    end
    step; step; step;
    chk("rr_cnt", 32'(cnt[0]), 5);
    chk("rr_busy", 32'(busy[0]), 0);
    ready = 1'b0; done = 1'b0;

    do_reset;
    req = 4'b0100; ready = 1'b1;
    step;
    chk("to_gnt", 32'(gnt[1]), 4);
    req = '0; n = 0;
    while (fault[1] !== 1'b1 && n < 10) begin step; n++; end
    chk("to_latency", n, 4);
    chk("to_fault_id", 32'(fid[1]), 2);
    chk("to_gnt_clr", 32'(gnt[1]), 0);
    chk("to_busy", 32'(busy[1]), 1);
    step; step;
    chk("to_hold", 32'(fault[1]), 1);
    req = 4'b0101; clr = 1'b1; ready = 1'b0;
    step;
    clr = 1'b0;
    chk("clr_fault", 32'(fault[1]), 0);
    chk("clr_busy", 32'(busy[1]), 0);
    chk("clr_fid_hold", 32'(fid[1]), 2);
    step;
    chk("clr_next_gnt", 32'(gnt[1]), 1);
    req = '0;

    do_reset;
    req = 4'b0001;
    step;
    req = '0; ready = 1'b1;
    step;
    ready = 1'b0;
    step; step;
    done = 1'b1;
    step;
    done = 1'b0;
    chk("tie_nofault", 32'(fault[1]), 0);
    chk("tie_release_gnt", 32'(gnt[1]), 1);
    step;
    chk("tie_cnt", 32'(cnt[1]), 1);
    chk("tie_busy", 32'(busy[1]), 0);

    do_reset;
    cmd = {8'h00, 8'h00, 8'h5A, 8'hC3};
    for (int k = 0; k < 7; k++) txn0;
    chk("pre_rst_cnt", 32'(cnt[0]), 7);
    req = 4'b0001;
    step;
    req = '0; ready = 1'b1;
    step;
    ready = 1'b0;
    step;
    chk("pre_rst_busy", 32'(busy[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt[0]), 0);
    chk("arst_cmd", 32'(acmd[0]), 0);
    chk("arst_busy", 32'(busy[0]), 0);
    chk("arst_cnt", 32'(cnt[0]), 0);
    chk("arst_fid", 32'(fid[0]), 0);
    @(negedge clk);
    rst_n = 1'b1; req = 4'b0010;
    step;
    req = '0;
    chk("post_rst_gnt", 32'(gnt[0]), 2);
    chk("post_rst_cmd", 32'(acmd[0]), 32'h5A);
    ready = 1'b1; done = 1'b1;
    step; step; step;
    ready = 1'b0; done = 1'b0;

    do_reset;
    force u0.o_cmd_count = 16'hFFFF;
    @(negedge clk);
    release u0.o_cmd_count;
    #1;
    chk("wrap_pre", 32'(cnt[0]), 32'hFFFF);
    txn0;
    chk("wrap_cnt", 32'(cnt[0]), 0);

    do_reset;
    m_owner = -1; m_age = 0; m_fid = 0; m_rr = 0; m_cnt = 0;
    m_acked = 0; m_done = 0; m_fault = 0; m_cmd = '0;
    for (int c = 0; c < 3000; c++) begin
      req   = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      cmd   = $urandom;
      ready = 1'($urandom_range(0, 1));
      done  = ($urandom_range(0, 3) == 0);
      clr   = ($urandom_range(0, 4) == 0);
      if (m_fault) begin
        if (clr) begin m_fault = 0; m_rr = (m_fid + 1) % 4; end
      end else if (m_owner < 0) begin
        w = -1;
        for (int k = 0; k < 4; k++) if (w < 0 && req[(m_rr + k) % 4]) w = (m_rr + k) % 4;
        if (w >= 0) begin
          m_owner = w; m_cmd = cmd[w*8 +: 8]; m_acked = 0; m_done = 0; m_age = 0;
        end
      end else if (m_done) begin
        m_cnt = (m_cnt + 1) % 65536; m_rr = (m_owner + 1) % 4; m_owner = -1;
      end else begin
        m_age++;
        if (m_acked && done) m_done = 1;
        else if (m_age == 4) begin m_fault = 1; m_fid = m_owner; m_owner = -1; end
        else if (!m_acked && ready) m_acked = 1;
      end
      step;
      chk("rnd_gnt", 32'(gnt[1]), m_owner >= 0 ? 32'(1) << m_owner : 0);
      chk("rnd_valid", 32'(valid[1]), 32'(m_owner >= 0 && !m_acked));
      chk("rnd_cmd", 32'(acmd[1]), 32'(m_cmd));
      chk("rnd_busy", 32'(busy[1]), 32'(m_owner >= 0 || m_fault));
      chk("rnd_fault", 32'(fault[1]), 32'(m_fault));
      chk("rnd_fid", 32'(fid[1]), m_fid);
      chk("rnd_cnt", 32'(cnt[1]), m_cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
